// File: rtl/freq_meter_pkg.sv
// Shared constants for the BCD frequency meter: digit width and active-high
// seven-segment codes laid out as {dp,g,f,e,d,c,b,a}.
package freq_meter_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DP    = 8'h80;

  function automatic logic [7:0] bcd_to_seg(input logic [DIGIT_W-1:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan.sv
// Time-multiplexed display driver: walks the digits, applies leading-zero
// blanking and overflow rendering, and registers digit and segment together.
module seg_scan
  import freq_meter_pkg::*;
#(
  parameter int NDIGITS     = 8,
  parameter int SCAN_CYCLES = 1000,
  parameter int SEG_ACT_LOW = 1,
  parameter int BLANK_LZ    = 1
) (
  input  logic                       clck,
  input  logic                       rst_n,
  input  logic [NDIGITS*DIGIT_W-1:0] value,
  input  logic                       ovf,
  output logic [NDIGITS-1:0]         digit,
  output logic [7:0]                 segment
);

  localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int IDX_W  = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [NDIGITS-1:0] DIG_OFF = {NDIGITS{SEG_ACT_LOW != 0}};
  localparam logic [7:0]         SEG_OFF = {8{SEG_ACT_LOW != 0}};

  logic [SCAN_W-1:0]  scan_cnt;
  logic [IDX_W-1:0]   idx;
  logic               scan_end;
  logic               load;
  logic [DIGIT_W-1:0] nib;
  logic [NDIGITS-1:0] onehot;
  logic               lit;
  logic [7:0]         seg_hi;

  assign scan_end = (scan_cnt == SCAN_W'(SCAN_CYCLES - 1));
  assign load     = (scan_cnt == '0);

  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else begin
      scan_cnt <= scan_end ? '0 : scan_cnt + SCAN_W'(1);
      if (scan_end) begin
        idx <= (idx == IDX_W'(NDIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end
    end
  end

  // lit: some digit at or above the current index is non-zero
  always_comb begin
    nib    = '0;
    onehot = '0;
    lit    = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (i >= int'(idx) && value[i*DIGIT_W +: DIGIT_W] != '0) lit = 1'b1;
      if (i == int'(idx)) begin
        nib       = value[i*DIGIT_W +: DIGIT_W];
        onehot[i] = 1'b1;
      end
    end
    if (ovf) begin
      seg_hi = bcd_to_seg(4'd9) | ((idx == '0) ? SEG_DP : SEG_BLANK);
    end else if (BLANK_LZ != 0 && idx != '0 && !lit) begin
      seg_hi = SEG_BLANK;
    end else begin
      seg_hi = bcd_to_seg(nib);
    end
  end

  // Outputs change only at a digit boundary, so a new value never lands mid-digit
  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) begin
      digit   <= DIG_OFF;
      segment <= SEG_OFF;
    end else if (load) begin
      digit   <= onehot ^ DIG_OFF;
      segment <= seg_hi ^ SEG_OFF;
    end
  end

endmodule

// File: rtl/freq_meter_bcd.sv
// Gated frequency counter: counts synchronised rising edges of sigin in BCD over
// a fixed gate window and hands the latched result to the display scanner.
module freq_meter_bcd
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 100000,
  parameter int NDIGITS     = 8,
  parameter int SCAN_CYCLES = 1000,
  parameter int SEG_ACT_LOW = 1,
  parameter int BLANK_LZ    = 1
) (
  input  logic               clck,
  input  logic               rst_n,
  input  logic               sigin,
  input  logic               hold,
  output logic [NDIGITS-1:0] digit,
  output logic [7:0]         segment,
  output logic               result_valid,
  output logic               overflow
);

  localparam int CNT_W  = NDIGITS * DIGIT_W;
  localparam int GATE_W = $clog2(GATE_CYCLES);

  logic              sig_p0, sig_p1, sig_p2;
  logic              sig_edge;
  logic [GATE_W-1:0] gate_cnt;
  logic              gate_end;
  logic [CNT_W-1:0]  cnt;
  logic              ovf_acc;
  logic              cnt_full;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  win_result;
  logic              win_ovf;
  logic [CNT_W-1:0]  disp_reg;

  function automatic logic [CNT_W-1:0] bcd_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    logic             carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (carry) begin
        if (v[i*DIGIT_W +: DIGIT_W] == 4'd9) begin
          r[i*DIGIT_W +: DIGIT_W] = '0;
        end else begin
          r[i*DIGIT_W +: DIGIT_W] = v[i*DIGIT_W +: DIGIT_W] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic all_nines(input logic [CNT_W-1:0] v);
    logic r;
    r = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (v[i*DIGIT_W +: DIGIT_W] != 4'd9) r = 1'b0;
    end
    return r;
  endfunction

  // Stage p0/p1 synchronise sigin, p2 holds the previous sample for edge detect
  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) begin
      sig_p0 <= 1'b0;
      sig_p1 <= 1'b0;
      sig_p2 <= 1'b0;
    end else begin
      sig_p0 <= sigin;
      sig_p1 <= sig_p0;
      sig_p2 <= sig_p1;
    end
  end

  assign sig_edge = sig_p1 & ~sig_p2;
  assign gate_end = (gate_cnt == GATE_W'(GATE_CYCLES - 1));

  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) gate_cnt <= '0;
    else        gate_cnt <= gate_end ? '0 : gate_cnt + GATE_W'(1);
  end

  // Window result already includes an edge arriving in the terminal cycle
  always_comb begin
    cnt_full   = all_nines(cnt);
    cnt_inc    = bcd_inc(cnt);
    win_result = (sig_edge && !cnt_full) ? cnt_inc : cnt;
    win_ovf    = ovf_acc | (sig_edge & cnt_full);
  end

  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      ovf_acc <= 1'b0;
    end else if (gate_end) begin
      cnt     <= '0;
      ovf_acc <= 1'b0;
    end else begin
      cnt     <= win_result;
      ovf_acc <= win_ovf;
    end
  end

  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) begin
      result_valid <= 1'b0;
      disp_reg     <= '0;
      overflow     <= 1'b0;
    end else begin
      result_valid <= gate_end;
      if (gate_end && !hold) begin
        disp_reg <= win_result;
        overflow <= win_ovf;
      end
    end
  end

  seg_scan #(
    .NDIGITS     (NDIGITS),
    .SCAN_CYCLES (SCAN_CYCLES),
    .SEG_ACT_LOW (SEG_ACT_LOW),
    .BLANK_LZ    (BLANK_LZ)
  ) u_scan (
    .clck    (clck),
    .rst_n   (rst_n),
    .value   (disp_reg),
    .ovf     (overflow),
    .digit   (digit),
    .segment (segment)
  );

endmodule
